mult_div_seq: RTL and testbench



---
 rtl/mdu_defs.sv | 18 +
 rtl/mdu_step.sv | 38 +++
 rtl/mult_div_seq.sv | 160 ++++++++++++++++
 tb/tb_mult_div_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_defs.sv
// Shared encodings for the multiply/divide sequencer.
// Holds FSM state codes, op codes and the default operand width.
package mdu_defs;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration: shift-add multiply or restoring divide.
// Ports: op_i, work_i/opnd_i in; work_o (next work reg), qbit_o out.
module mdu_step
    import mdu_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               op_i,
    input  logic [2*WIDTH-1:0] work_i,
    input  logic [WIDTH-1:0]   opnd_i,
    output logic [2*WIDTH-1:0] work_o,
    output logic               qbit_o
);

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] sh;

    always_comb begin
        sum = {1'b0, work_i[2*WIDTH-1:WIDTH]};
        if (work_i[0]) begin
            sum = sum + {1'b0, opnd_i};
        end
        // Remainder stays below the divisor magnitude, so the top
        // bit dropped by the shift is always zero.
        sh     = {work_i[2*WIDTH-2:0], 1'b0};
        diff   = {1'b0, sh[2*WIDTH-1:WIDTH]} - {1'b0, opnd_i};
        work_o = sh;
        qbit_o = 1'b0;
        if (op_i == OP_MULT) begin
            work_o = {sum, work_i[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            work_o = {diff[WIDTH-1:0], sh[WIDTH-1:0]};
            qbit_o = 1'b1;
        end
    end

endmodule

// File: rtl/mult_div_seq.sv
// Iterative signed MULT/DIV sequencer owning the Hi/Lo registers.
// Ports: clk, reset, start, op, a_in, b_in -> busy, done, div0, hi/lo.
module mult_div_seq
    import mdu_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [2*WIDTH-1:0] step_w;
    logic               step_q;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // MULT adds |a| into the accumulator; DIV subtracts |b|.
    assign opnd = (op_q == OP_DIV) ? b_q : a_q;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .op_i   (op_q),
        .work_i (work_q),
        .opnd_i (opnd),
        .work_o (step_w),
        .qbit_o (step_q)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        a_mag = a_q[WIDTH-1] ? -a_q : a_q;
        b_mag = b_q[WIDTH-1] ? -b_q : b_q;
        prod  = neg_res_q ? -work_q : work_q;
        quot  = work_q[WIDTH-1:0];
        rem   = work_q[2*WIDTH-1:WIDTH];

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a_in;
                    b_d     = b_in;
                    div0_d  = 1'b0;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                neg_res_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
                neg_rem_d = a_q[WIDTH-1];
                a_d       = a_mag;
                b_d       = b_mag;
                if (op_q == OP_DIV && b_q == '0) begin
                    div0_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = '0;
                    // Low half holds the multiplier or dividend.
                    work_d  = (op_q == OP_DIV) ?
                              {{WIDTH{1'b0}}, a_mag} :
                              {{WIDTH{1'b0}}, b_mag};
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                work_d = {step_w[2*WIDTH-1:1], step_w[0] | step_q};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (op_q == OP_MULT) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    lo_d = neg_res_q ? -quot : quot;
                    hi_d = neg_rem_q ? -rem : rem;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign div0   = done & div0_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

endmodule

// File: tb/tb_mult_div_seq.sv
// Self-checking bench for mult_div_seq: vector table, corner sequences,
// and random ops against a plain-arithmetic signed reference model.
module tb_mult_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div0;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    mult_div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a_in   (a_in),
        .b_in   (b_in),
        .busy   (busy),
        .done   (done),
        .div0   (div0),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        d0;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, exp);
        end
    endtask

    function automatic void model(input logic o, input logic [31:0] x,
                                  input logic [31:0] y,
                                  input logic [31:0] ph,
                                  input logic [31:0] pl,
                                  output logic [31:0] h,
                                  output logic [31:0] l,
                                  output logic d0);
        longint sx;
        longint sy;
        longint p;
        longint q;
        longint r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        d0 = 1'b0;
        h  = ph;
        l  = pl;
        if (o == 1'b0) begin
            p = sx * sy;
            h = p[63:32];
            l = p[31:0];
        end else if (y == 32'd0) begin
            d0 = 1'b1;
        end else begin
            q = sx / sy;
            r = sx % sy;
            l = q[31:0];
            h = r[31:0];
        end
    endfunction

    // Issues one op, waits for done, checks latency/results/pulse.
    // inj_k > 0 pulses a stray DIV start so it lands on edge E(inj_k).
    task automatic run_op(input string nm, input logic o,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic ed0, input int inj_k);
        int k;
        bit seen;
        bit bz_ok;
        op    = o;
        a_in  = x;
        b_in  = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~o;
        a_in  = $urandom;
        b_in  = $urandom;
        chk({nm, " busy_e0"}, 64'(busy), 64'd1);
        k     = 0;
        seen  = 0;
        bz_ok = 1;
        while (!seen && k < 100) begin
            if (inj_k != 0 && k == inj_k - 1) begin
                start = 1'b1;
                op    = 1'b1;
                a_in  = 32'd9;
                b_in  = 32'd3;
            end
            @(posedge clk);
            k++;
            #1;
            start = 1'b0;
            if (done) seen = 1;
            else if (!busy) bz_ok = 0;
        end
        chk({nm, " done_seen"}, 64'(seen), 64'd1);
        chk({nm, " busy_run"}, 64'(bz_ok), 64'd1);
        chk({nm, " latency"}, 64'(k), ed0 ? 64'd1 : 64'd34);
        chk({nm, " div0"}, 64'(div0), 64'(ed0));
        chk({nm, " hi"}, 64'(hi_out), 64'(eh));
        chk({nm, " lo"}, 64'(lo_out), 64'(el));
        @(posedge clk);
        #1;
        chk({nm, " done_pulse"}, 64'({done, busy}), 64'd0);
        chk({nm, " hi_hold"}, 64'(hi_out), 64'(eh));
        chk({nm, " lo_hold"}, 64'(lo_out), 64'(el));
        m_hi = eh;
        m_lo = el;
    endtask

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic        ed;
        logic        ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          k;
        bit          seen;

        tbl[0] = '{1'b0, 32'd7, 32'hFFFFFFFD,
                   32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1] = '{1'b1, 32'hFFFFFFF9, 32'd2,
                   32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[2] = '{1'b1, 32'd7, 32'hFFFFFFFE,
                   32'd1, 32'hFFFFFFFD, 1'b0};
        tbl[3] = '{1'b0, 32'h80000000, 32'h80000000,
                   32'h40000000, 32'd0, 1'b0};
        tbl[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF,
                   32'd0, 32'h80000000, 1'b0};
        tbl[5] = '{1'b0, 32'h2AAAAAAB, 32'h66,
                   32'h11, 32'h22, 1'b0};
        tbl[6] = '{1'b1, 32'd5, 32'd0,
                   32'h11, 32'h22, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'({done, div0}), 64'd0);
        chk("rst hi", 64'(hi_out), 64'd0);
        chk("rst lo", 64'(lo_out), 64'd0);
        reset = 1'b0;
        m_hi  = '0;
        m_lo  = '0;

        for (int i = 0; i < 7; i++) begin
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a,
                   tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].d0, 0);
        end

        run_op("ign_start", 1'b0, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 5);

        op    = 1'b0;
        a_in  = 32'd3;
        b_in  = 32'd4;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        seen  = 0;
        for (k = 1; k <= 10; k++) begin
            if (k == 10) reset = 1'b1;
            @(posedge clk);
            #1;
            if (done) seen = 1;
        end
        reset = 1'b0;
        chk("rst_mid done", 64'(seen), 64'd0);
        chk("rst_mid busy", 64'(busy), 64'd0);
        chk("rst_mid hi", 64'(hi_out), 64'd0);
        chk("rst_mid lo", 64'(lo_out), 64'd0);
        run_op("after_rst", 1'b1, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 0);

        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: rb = 32'hFFFFFFFF;
                3: ra = 32'h80000000;
                default: ;
            endcase
            model(ro, ra, rb, m_hi, m_lo, eh, el, ed);
            run_op($sformatf("rnd%0d", i), ro, ra, rb, eh, el, ed, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
